// File: rtl/l1_cache_ctrl_if.sv
// l1_cache_ctrl_if
//   Bundles the requester-side and backing-memory-side signals of the L1 cache
//   controller.
//   slave  : the cache controller (takes requests, drives the memory strobes)
//   master : the environment (pipeline requester plus backing memory)
//   Signals:
//     req_valid/req_wr/req_addr/req_wdata   access request from the pipeline
//     rdata/hit/stall                       load result and pipeline freeze
//     mem_en/mem_wr/mem_addr/mem_wdata      backing-memory access
//     mem_rdata/mem_rvalid                  backing-memory read return
interface l1_cache_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] rdata;
   logic              hit;
   logic              stall;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
      output rdata, hit, stall, mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
      input  rdata, hit, stall, mem_en, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl
//   Blocking write-through, no-write-allocate L1 cache (1 or 2 ways) with a
//   miss FSM (IDLE -> FILL -> DONE) that refills one block from a pipelined
//   backing memory.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    l1_cache_ctrl_if.slave (request, load result, memory port)
module l1_cache_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int WPB     = 8,
   parameter int SETS    = 64,
   parameter int WAYS    = 2,
   parameter int MEM_LAT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   l1_cache_ctrl_if.slave bus
);
   localparam int OFF_W     = $clog2(WPB);
   localparam int IDX_W     = $clog2(SETS);
   localparam int LINE_W    = IDX_W + OFF_W;
   localparam int TAG_W     = ADDR_W - 1 - LINE_W;
   // The fill window (issue phase plus memory latency) is timed by one counter.
   localparam int FILL_CYC  = MEM_LAT + WPB;
   localparam int CYC_W     = $clog2(FILL_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
   state_t r_state, w_state_next;

   // Storage: data and tags are never reset, only valid/LRU are.
   logic [DATA_W-1:0] r_data    [WAYS][SETS*WPB];
   logic [TAG_W-1:0]  r_tag_mem [WAYS][SETS];
   logic [SETS-1:0]   r_valid   [WAYS];
   logic [SETS-1:0]   r_lru;      // per set: index of the least recently used way

   logic [TAG_W-1:0]  r_fill_tag;
   logic [IDX_W-1:0]  r_fill_idx;
   logic              r_fill_way;
   logic [CYC_W-1:0]  r_cyc;
   logic [OFF_W-1:0]  r_recv_cnt;

   logic [OFF_W-1:0]  w_off;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [WAYS-1:0]   w_way_hit;
   logic              w_hit_any, w_hit_way, w_victim;
   logic              w_idle_req, w_load_hit, w_load_miss, w_store, w_store_hit;
   logic              w_fill_rx, w_fill_last, w_issue;
   logic              w_hit, w_stall, w_mem_en, w_mem_wr;
   logic [DATA_W-1:0] w_rdata, w_mem_wdata;
   logic [ADDR_W-1:0] w_mem_addr;

   assign w_off = bus.req_addr[OFF_W:1];
   assign w_idx = bus.req_addr[LINE_W:OFF_W+1];
   assign w_tag = bus.req_addr[ADDR_W-1:LINE_W+1];

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         assign w_way_hit[gi] = r_valid[gi][w_idx] && (r_tag_mem[gi][w_idx] == w_tag);
      end
   endgenerate

   assign w_hit_any = |w_way_hit;
   assign w_hit_way = (WAYS > 1) ? w_way_hit[WAYS-1] : 1'b0;
   // Victim: first invalid way (way 0 first), otherwise the LRU way.
   assign w_victim  = (WAYS == 1)                ? 1'b0 :
                      !r_valid[0][w_idx]         ? 1'b0 :
                      !r_valid[WAYS-1][w_idx]    ? 1'b1 : r_lru[w_idx];

   // Requests only count in IDLE; rst_n gating keeps every output low during reset.
   assign w_idle_req  = rst_n && (r_state == S_IDLE) && bus.req_valid;
   assign w_load_hit  = w_idle_req && !bus.req_wr && w_hit_any;
   assign w_load_miss = w_idle_req && !bus.req_wr && !w_hit_any;
   assign w_store     = w_idle_req && bus.req_wr;
   assign w_store_hit = w_store && w_hit_any;
   assign w_fill_rx   = (r_state == S_FILL) && bus.mem_rvalid;
   assign w_fill_last = w_fill_rx && (&r_recv_cnt);
   assign w_issue     = (r_state == S_FILL) && (r_cyc < CYC_W'(WPB));

   always_comb begin
      w_state_next = r_state;
      w_hit        = 1'b0;
      w_stall      = 1'b0;
      w_rdata      = '0;
      w_mem_en     = 1'b0;
      w_mem_wr     = 1'b0;
      w_mem_addr   = '0;
      w_mem_wdata  = '0;
      case (r_state)
         S_IDLE: begin
            if (w_load_hit) begin
               w_hit   = 1'b1;
               w_rdata = r_data[w_hit_way][{w_idx, w_off}];
            end else if (w_load_miss) begin
               w_stall      = 1'b1;
               w_state_next = S_FILL;
            end else if (w_store) begin
               w_mem_en    = 1'b1;
               w_mem_wr    = 1'b1;
               w_mem_addr  = bus.req_addr;
               w_mem_wdata = bus.req_wdata;
            end
         end
         S_FILL: begin
            w_stall = 1'b1;
            if (w_issue) begin
               w_mem_en   = 1'b1;
               w_mem_addr = {r_fill_tag, r_fill_idx, r_cyc[OFF_W-1:0], 1'b0};
            end
            if (w_fill_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            w_stall      = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
         r_lru      <= '0;
         r_fill_tag <= '0;
         r_fill_idx <= '0;
         r_fill_way <= 1'b0;
         r_cyc      <= '0;
         r_recv_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load_miss) begin
            r_fill_tag <= w_tag;
            r_fill_idx <= w_idx;
            r_fill_way <= w_victim;
            r_cyc      <= '0;
            r_recv_cnt <= '0;
            // The victim's data is about to be overwritten word by word.
            r_valid[w_victim][w_idx] <= 1'b0;
         end
         if ((w_load_hit || w_store_hit) && (WAYS > 1)) r_lru[w_idx] <= ~w_hit_way;
         if ((r_state == S_FILL) && (r_cyc != CYC_W'(FILL_CYC))) r_cyc <= r_cyc + 1'b1;
         if (w_fill_rx) r_recv_cnt <= r_recv_cnt + 1'b1;
         if (w_fill_last) begin
            r_valid[r_fill_way][r_fill_idx] <= 1'b1;
            if (WAYS > 1) r_lru[r_fill_idx] <= ~r_fill_way;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_rx)   r_data[r_fill_way][{r_fill_idx, r_recv_cnt}] <= bus.mem_rdata;
      if (w_store_hit) r_data[w_hit_way][{w_idx, w_off}] <= bus.req_wdata;
      if (w_fill_last) r_tag_mem[r_fill_way][r_fill_idx] <= r_fill_tag;
   end

   assign bus.hit       = w_hit;
   assign bus.stall     = w_stall;
   assign bus.rdata     = w_rdata;
   assign bus.mem_en    = w_mem_en;
   assign bus.mem_wr    = w_mem_wr;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
endmodule
